// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight GPR writes, stalls issue on RAW/WAW/full.
// Optional same-cycle writeback bypass of the RAW check: REG_SCOREBOARD_BYPASS_EN.
module reg_scoreboard #(
    parameter int MAX_OUT = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic        issue_use_rt,
    input  logic        issue_wr,
    input  logic [4:0]  issue_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] busy_vec,
    output logic [3:0]  out_cnt,
    output logic        err
);

    logic [31:0] r_pending;
    logic [3:0]  r_out_cnt;
    logic        r_err;

    logic        w_rs_raw;
    logic        w_rt_raw;
    logic        w_raw;
    logic        w_waw;
    logic        w_full;
    logic        w_stall;
    logic        w_set;
    logic        w_wb_live;
    logic        w_wb_hit;
    logic        w_wb_err;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;

    always_comb begin
        w_rs_raw = r_pending[issue_rs];
        w_rt_raw = issue_use_rt & r_pending[issue_rt];
`ifdef REG_SCOREBOARD_BYPASS_EN
        // A writeback landing this cycle satisfies a reader of the same register.
        if (wb_valid && (wb_rd == issue_rs)) w_rs_raw = 1'b0;
        if (wb_valid && (wb_rd == issue_rt)) w_rt_raw = 1'b0;
`endif
        w_raw   = issue_valid & (w_rs_raw | w_rt_raw);
        w_waw   = issue_valid & issue_wr & r_pending[issue_rd];
        w_full  = issue_valid & issue_wr & (issue_rd != 5'd0) & (r_out_cnt == 4'(MAX_OUT));
        w_stall = (w_raw | w_waw | w_full) & ~clr & ~flush;

        w_set     = issue_valid & ~w_stall & issue_wr & (issue_rd != 5'd0);
        w_wb_live = wb_valid & (wb_rd != 5'd0);
        w_wb_hit  = w_wb_live & r_pending[wb_rd];
        w_wb_err  = w_wb_live & ~r_pending[wb_rd];

        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_set)    w_set_mask[issue_rd] = 1'b1;
        if (w_wb_hit) w_clr_mask[wb_rd]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_pending <= '0;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else if (flush) begin
            r_pending <= '0;
            r_out_cnt <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            r_out_cnt <= r_out_cnt + {3'b000, w_set} - {3'b000, w_wb_hit};
            if (w_wb_err) r_err <= 1'b1;
        end
    end

    assign stall    = w_stall;
    assign busy_vec = {r_pending[31:1], 1'b0};
    assign out_cnt  = r_out_cnt;
    assign err      = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: behavioural model feeds an expected-state queue.
module tb_reg_scoreboard;

    localparam int MAX_OUT = 8;

    logic        clk;
    logic        clr;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_use_rt;
    logic        issue_wr;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [31:0] busy_vec;
    logic [3:0]  out_cnt;
    logic        err;

    reg_scoreboard #(.MAX_OUT(MAX_OUT)) dut (
        .clk          (clk),
        .clr          (clr),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_use_rt (issue_use_rt),
        .issue_wr     (issue_wr),
        .issue_rd     (issue_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .stall        (stall),
        .busy_vec     (busy_vec),
        .out_cnt      (out_cnt),
        .err          (err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // expected state after each cycle: {err, out_cnt, busy_vec}
    logic [36:0] exp_q[$];

    // reference model state
    logic [31:0] m_pend = '0;
    int          m_cnt  = 0;
    logic        m_err  = 1'b0;
    logic        last_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_stall();
        logic rs_hit, rt_hit, raw, waw, full;
        rs_hit = m_pend[issue_rs];
        rt_hit = issue_use_rt && m_pend[issue_rt];
`ifdef REG_SCOREBOARD_BYPASS_EN
        if (wb_valid && wb_rd == issue_rs) rs_hit = 1'b0;
        if (wb_valid && wb_rd == issue_rt) rt_hit = 1'b0;
`endif
        raw  = issue_valid && (rs_hit || rt_hit);
        waw  = issue_valid && issue_wr && m_pend[issue_rd];
        full = issue_valid && issue_wr && issue_rd != 0 && m_cnt == MAX_OUT;
        if (clr || flush) return 1'b0;
        return raw || waw || full;
    endfunction

    task automatic model_step(input logic st);
        logic [31:0] old;
        old = m_pend;
        if (clr) begin
            m_pend = '0; m_cnt = 0; m_err = 1'b0;
        end else if (flush) begin
            m_pend = '0; m_cnt = 0;
        end else begin
            if (wb_valid && wb_rd != 0) begin
                if (old[wb_rd]) begin
                    m_pend[wb_rd] = 1'b0;
                    m_cnt--;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (issue_valid && !st && issue_wr && issue_rd != 0) begin
                m_pend[issue_rd] = 1'b1;
                m_cnt++;
            end
        end
    endtask

    // Drive one cycle starting just after a negedge; check stall, then registered state.
    task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic wr, input logic [4:0] rd,
                       input logic wbv, input logic [4:0] wbrd,
                       input logic fl, input logic cl);
        logic st;
        logic [36:0] e;
        issue_valid = v; issue_rs = rs; issue_rt = rt; issue_use_rt = urt;
        issue_wr = wr; issue_rd = rd; wb_valid = wbv; wb_rd = wbrd;
        flush = fl; clr = cl;
        #1;
        st = model_stall();
        check("stall", 64'(stall), 64'(st));
        last_stall = stall;
        model_step(st);
        exp_q.push_back({m_err, 4'(m_cnt), m_pend});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("busy_vec", 64'(busy_vec), 64'(e[31:0]));
        check("out_cnt", 64'(out_cnt), 64'(e[35:32]));
        check("err", 64'(err), 64'(e[36]));
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_clr();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rt = 0;
        issue_wr = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0; flush = 0; clr = 1;
        @(negedge clk);

        // reset state
        do_clr();
        check("rst_busy", 64'(busy_vec), 64'h0);
        check("rst_cnt", 64'(out_cnt), 64'h0);
        check("rst_err", 64'(err), 64'h0);

        // issue rd=5, then dependent rs=5
        cyc(1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        check("issue5_busy", 64'(busy_vec), 64'h20);
        check("issue5_cnt", 64'(out_cnt), 64'h1);
        cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        check("raw5_stall", 64'(last_stall), 64'h1);

        // RAW release via writeback of r5
        cyc(1, 5, 0, 0, 0, 0, 1, 5, 0, 0);
`ifdef REG_SCOREBOARD_BYPASS_EN
        check("wb_cycle_stall", 64'(last_stall), 64'h0);
`else
        check("wb_cycle_stall", 64'(last_stall), 64'h1);
        cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        check("after_wb_stall", 64'(last_stall), 64'h0);
`endif
        // rt-side RAW
        cyc(1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        cyc(1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        check("raw_rt_stall", 64'(last_stall), 64'h1);
        cyc(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        check("rt_unused_stall", 64'(last_stall), 64'h0);

        // full
        do_clr();
        for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, 1, 5'(i), 0, 0, 0, 0);
        check("full_cnt", 64'(out_cnt), 64'd8);
        cyc(1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        check("full_stall", 64'(last_stall), 64'h1);
        cyc(1, 0, 0, 0, 1, 9, 1, 3, 0, 0);
        check("wb3_cnt", 64'(out_cnt), 64'd7);
        cyc(1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        check("r9_accept", 64'(last_stall), 64'h0);
        check("r9_cnt", 64'(out_cnt), 64'd8);
        // a $0 write is never full-stalled
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("full_r0_stall", 64'(last_stall), 64'h0);

        // $0 handling
        do_clr();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        check("r0_busy", 64'(busy_vec), 64'h0);
        check("r0_cnt", 64'(out_cnt), 64'h0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("wb_r0_err", 64'(err), 64'h0);

        // protocol error, sticky through flush
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        check("err_set", 64'(err), 64'h1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("err_flush_hold", 64'(err), 64'h1);
        do_clr();
        check("err_clr", 64'(err), 64'h0);

        // flush mid-stall
        cyc(1, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 6, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pre_flush_stall", 64'(last_stall), 64'h1);
        cyc(1, 4, 0, 0, 0, 0, 0, 0, 1, 0);
        check("flush_stall", 64'(last_stall), 64'h0);
        check("flush_busy", 64'(busy_vec), 64'h0);
        check("flush_cnt", 64'(out_cnt), 64'h0);

        // clr mid-stall with err set
        cyc(1, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 6, 1, 11, 0, 0);
        cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pre_clr_stall", 64'(last_stall), 64'h1);
        cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        check("clr_stall", 64'(last_stall), 64'h0);
        check("clr_busy", 64'(busy_vec), 64'h0);
        check("clr_cnt", 64'(out_cnt), 64'h0);
        check("clr_err", 64'(err), 64'h0);

        // random traffic, writebacks mostly aimed at pending registers
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr_sel;
            logic [4:0] start;
            wr_sel = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 8) begin
                start = 5'($urandom_range(0, 31));
                for (int k = 0; k < 32; k++) begin
                    if (m_pend[5'(start + 5'(k))]) begin
                        wr_sel = 5'(start + 5'(k));
                        break;
                    end
                end
            end
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), wr_sel,
                1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 79) == 0));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard for the CPU issue stage. It tracks which of the 32 GPRs (5-bit register addresses) have writes in flight from multi-cycle units. It stalls issue on RAW/WAW hazards or when too many writes are outstanding, and clears entries on writeback. It sits between decode/issue and the 5-bit destination-register pipeline flops that carry rd to writeback.

## Interface
Parameters:
- MAX_OUT, 8: maximum simultaneous outstanding writes (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-high.
- issue_valid  in  1  issue stage presents an instruction this cycle.
- issue_rs  in  5  source register 1.
- issue_rt  in  5  source register 2.
- issue_use_rt  in  1  instruction reads rt.
- issue_wr  in  1  instruction writes issue_rd.
- issue_rd  in  5  destination register.
- wb_valid  in  1  writeback completes this cycle.
- wb_rd  in  5  register being written back.
- flush  in  1  discard all in-flight writes.
- stall  out  1  combinational; issue must hold, instruction not accepted.
- busy_vec  out  32  registered pending bit per GPR.
- out_cnt  out  4  registered count of pending writes.
- err  out  1  registered sticky protocol-error flag.

## Operation
- State: pending[31:0], out_cnt, err. pending[0] is hardwired 0. Writes to $0 are never tracked and never counted.
- Hazard (combinational):
  - raw = issue_valid & (pending[issue_rs] | issue_use_rt & pending[issue_rt]).
  - waw = issue_valid & issue_wr & pending[issue_rd].
  - full = issue_valid & issue_wr & (issue_rd != 0) & (out_cnt == MAX_OUT).
  - stall = raw | waw | full. Forced 0 while clr or flush is high.
- Accept: issue_valid & ~stall. If also issue_wr and issue_rd != 0, then pending[issue_rd] is set and out_cnt is incremented.
- Writeback: when wb_valid and wb_rd != 0:
  - If pending[wb_rd] is set, clear it and decrement out_cnt.
  - If pending[wb_rd] is clear, set err and leave pending and out_cnt unchanged.
  - wb_valid with wb_rd == 0 is ignored.
- Same-cycle accept and writeback:
  - Different registers: both take effect; out_cnt is unchanged net.
  - Same register: cannot be accepted, because waw stalls it.
- Priority order: clr > flush > normal update.
  - flush: pending and out_cnt go to 0 next cycle; err is held; issue and wb that cycle are ignored.
  - clr: pending, out_cnt and err all go to 0.

## Timing
- Reset values: busy_vec = 0, out_cnt = 0, err = 0, stall = 0.
- stall is combinational from the inputs and the registered pending vector. It must settle within the same cycle.
- Accepted write: busy_vec bit visible the cycle after acceptance; a dependent instruction in the next cycle stalls.
- Writeback: busy_vec bit clears one cycle after wb_valid. A stalled consumer is accepted the following cycle, unless bypass is enabled.
- out_cnt never exceeds MAX_OUT and never underflows.
- clr or flush asserted mid-stall releases the stall the same cycle.

## Configuration
- REG_SCOREBOARD_BYPASS_EN:
  - Defined: a same-cycle writeback with wb_rd equal to a source masks that source's raw term. The issue is accepted in the writeback cycle, saving one stall cycle.
  - Undefined: raw uses the registered pending bits only. The consumer waits one cycle after wb_valid.
  - waw and full are identical in both builds.

## Test plan
- Reset, then issue rd=5 and the next cycle issue rs=5: busy_vec=0x20 and out_cnt=1 after the first issue; stall=1 on the second issue.
- RAW release: pending r5; wb_valid with wb_rd=5.
  - Bypass undefined: stall=1 in the wb cycle, stall=0 the next cycle.
  - Bypass defined: stall=0 in the wb cycle.
- Full: MAX_OUT=8, issue writes to r1..r8 -> out_cnt=8. A ninth write (rd=9) stalls. Writeback r3 -> out_cnt=7, and r9 is accepted the next cycle.
- $0 handling: issue rd=0 and rs=0 repeatedly -> never stalls; busy_vec and out_cnt stay 0.
- Protocol error: wb_valid with wb_rd=7 while r7 is not pending -> err=1 next cycle. err holds through flush and clears only on clr.
- Flush and reset mid-operation: with r2, r4 and r6 pending and an issue of rs=4 stalled, assert flush -> stall=0 that cycle; the next cycle busy_vec=0 and out_cnt=0. Repeat with clr instead of flush: same result and err=0.
